sprite_blit_scheduler: RTL and testbench

Arbitrates between up to N_REQ sprite requesters (player/enemy tanks, bullets, base, explosions) for the single shared 16x16 sprite ROM. Walks the granted sprite's 256 palette-index pixels and writes each non-transparent pixel into the playfield framebuffer at the requested position, clipping pixels that fall off-screen. It sits between the game-logic FSMs and the framebuffer write port.

---
 rtl/sprite_blit_scheduler.sv | 161 ++++++++++++++++
 tb/tb_sprite_blit_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blit_scheduler.sv
// Round-robin arbiter for the shared 16x16 sprite ROM. It walks the granted sprite and writes
// each opaque, on-screen pixel into the playfield framebuffer through a two-stage pipeline.
module sprite_blit_scheduler #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned SPR_BITS = 3,
    parameter int unsigned FB_W     = 208,
    parameter int unsigned FB_H     = 208
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*SPR_BITS-1:0] sprite_id,
    input  logic [N_REQ*8-1:0]        pos_x,
    input  logic [N_REQ*8-1:0]        pos_y,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic [SPR_BITS+7:0]       rom_addr,
    input  logic [3:0]                rom_data,
    output logic                      fb_we,
    output logic [15:0]               fb_addr,
    output logic [3:0]                fb_data,
    input  logic                      fb_wait
);

    localparam int unsigned      RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [RR_W-1:0]  LAST   = RR_W'(N_REQ - 1);
    localparam logic [8:0]       FB_W9  = 9'(FB_W);
    localparam logic [8:0]       FB_H9  = 9'(FB_H);
    localparam logic [15:0]      FB_W16 = 16'(FB_W);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                r_state, w_state_d;
    logic [RR_W-1:0]       r_rr, r_gnt;
    logic [SPR_BITS-1:0]   r_id;
    logic [7:0]            r_x, r_y, r_cnt;
    logic                  r_s1_v;
    logic [3:0]            r_s1_row, r_s1_col;
    logic [3:0]            r_hold;
    logic                  r_hold_v;
    logic                  r_fb_we;
    logic [15:0]           r_fb_addr;
    logic [3:0]            r_fb_data;

    logic                  w_any;
    logic [RR_W-1:0]       w_pick, w_idx;
    logic [SPR_BITS-1:0]   w_id;
    logic [7:0]            w_x, w_y;
    logic                  w_stall, w_we;
    logic [3:0]            w_pix;
    logic [8:0]            w_ax, w_ay;
    logic [15:0]           w_addr;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = RR_W'((int'(r_rr) + i) % int'(N_REQ));
            if (!w_any && req[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_id = '0;
        w_x  = '0;
        w_y  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick == RR_W'(i)) begin
                w_id = sprite_id[i*SPR_BITS +: SPR_BITS];
                w_x  = pos_x[i*8 +: 8];
                w_y  = pos_y[i*8 +: 8];
            end
        end
    end

    // Only a write that is actually being presented can be held off by the framebuffer.
    assign w_stall = fb_wait && r_fb_we;
    // The ROM keeps reading during a stall, so the first stalled cycle's data is kept aside.
    assign w_pix   = r_hold_v ? r_hold : rom_data;
    assign w_ax    = {1'b0, r_x} + {5'b0, r_s1_col};
    assign w_ay    = {1'b0, r_y} + {5'b0, r_s1_row};
    assign w_we    = r_s1_v && (w_pix != 4'd0) && (w_ax < FB_W9) && (w_ay < FB_H9);
    assign w_addr  = 16'(w_ay) * FB_W16 + 16'(w_ax);

    always_comb begin
        w_state_d = r_state;
        busy      = (r_state != StIdle);
        done      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            done[i] = (r_state == StDone) && (r_gnt == RR_W'(i));
        end
        unique case (r_state)
            StIdle:  if (w_any) w_state_d = StRun;
            StRun:   if (!w_stall && (r_cnt == 8'hFF)) w_state_d = StDrain;
            StDrain: if (!w_stall && !r_s1_v) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= StIdle;
        else       r_state <= w_state_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr      <= '0;
            r_gnt     <= '0;
            r_id      <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_cnt     <= '0;
            r_s1_v    <= 1'b0;
            r_s1_row  <= '0;
            r_s1_col  <= '0;
            r_hold    <= '0;
            r_hold_v  <= 1'b0;
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else begin
            if (r_state == StIdle && w_any) begin
                r_gnt <= w_pick;
                r_id  <= w_id;
                r_x   <= w_x;
                r_y   <= w_y;
                r_cnt <= '0;
            end
            if (r_state == StDone) begin
                r_rr <= (r_gnt == LAST) ? '0 : r_gnt + 1'b1;
            end
            if (w_stall) begin
                r_hold   <= w_pix;
                r_hold_v <= 1'b1;
            end else begin
                r_hold_v <= 1'b0;
                if (r_state == StRun) r_cnt <= r_cnt + 8'd1;
                r_s1_v   <= (r_state == StRun);
                r_s1_row <= r_cnt[7:4];
                r_s1_col <= r_cnt[3:0];
                r_fb_we  <= w_we;
                if (r_s1_v) begin
                    r_fb_addr <= w_addr;
                    r_fb_data <= w_pix;
                end
            end
        end
    end

    assign rom_addr = {r_id, r_cnt};
    assign fb_we    = r_fb_we;
    assign fb_addr  = r_fb_addr;
    assign fb_data  = r_fb_data;

endmodule

// File: tb/tb_sprite_blit_scheduler.sv
// Bench for sprite_blit_scheduler: a pixel-level reference model queues every expected
// framebuffer write and done pulse; a monitor process pops and compares them as they appear.
module tb_sprite_blit_scheduler;

    localparam int N_REQ    = 4;
    localparam int SPR_BITS = 3;
    localparam int FB_W     = 208;
    localparam int FB_H     = 208;

    logic                      Clk = 1'b0;
    logic                      Reset;
    logic [N_REQ-1:0]          req;
    logic [N_REQ*SPR_BITS-1:0] sprite_id;
    logic [N_REQ*8-1:0]        pos_x, pos_y;
    logic [N_REQ-1:0]          done;
    logic                      busy;
    logic [SPR_BITS+7:0]       rom_addr;
    logic [3:0]                rom_data;
    logic                      fb_we;
    logic [15:0]               fb_addr;
    logic [3:0]                fb_data;
    logic                      fb_wait;

    sprite_blit_scheduler #(
        .N_REQ(N_REQ), .SPR_BITS(SPR_BITS), .FB_W(FB_W), .FB_H(FB_H)
    ) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .sprite_id(sprite_id), .pos_x(pos_x),
        .pos_y(pos_y), .done(done), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_wait(fb_wait)
    );

    always #5 Clk = ~Clk;

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int g; int cyc; } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];
    int  checks = 0, failures = 0, cyc = 0, n_wr = 0, m_rr = 0;
    int  rom_mode = 0, rom_seed = 0;

    // Sprite ROM contents: mode 0 all index 1, mode 1 all transparent, mode 2 hashed mix.
    function automatic logic [3:0] rom_val(int mode, int seed, int a);
        if (mode == 0) return 4'd1;
        if (mode == 1) return 4'd0;
        if (((a ^ seed) % 5) == 0) return 4'd0;
        return 4'((a * 13 + seed) ^ (a >> 5));
    endfunction

    always @(posedge Clk) rom_data <= rom_val(rom_mode, rom_seed, int'(rom_addr));
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic int pick(int rr, int mask);
        for (int i = 0; i < N_REQ; i++) begin
            if (((mask >> ((rr + i) % N_REQ)) & 1) != 0) return (rr + i) % N_REQ;
        end
        return -1;
    endfunction

    // Queue the writes of pixels 0..npix-1; pixels from stall_k on are delayed by stall_len.
    function automatic int push_blit(int g, int id, int x, int y, int c0, int npix,
                                     int stall_k, int stall_len);
        int  cnt, ax, ay;
        wr_t w;
        dn_t d;
        cnt = 0;
        for (int k = 0; k < npix; k++) begin
            ax = x + k % 16;
            ay = y + k / 16;
            w.data = int'(rom_val(rom_mode, rom_seed, id * 256 + k));
            if (w.data != 0 && ax < FB_W && ay < FB_H) begin
                w.addr = ay * FB_W + ax;
                w.cyc  = c0 + k + 3 + ((stall_len > 0 && k >= stall_k) ? stall_len : 0);
                exp_wr.push_back(w);
                cnt++;
            end
        end
        if (npix == 256) begin
            d.g   = g;
            d.cyc = c0 + 259 + stall_len;
            exp_dn.push_back(d);
        end
        return cnt;
    endfunction

    // Monitor: every accepted write and every done pulse is matched against the queues.
    initial begin
        wr_t w;
        dn_t d;
        bit  prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge Clk);
            if (Reset) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) check("busy_after_done", busy, 0);
                prev_done = (done != '0);
                if (fb_we && !fb_wait) begin
                    n_wr++;
                    if (exp_wr.size() == 0) begin
                        $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d",
                                 fb_addr, fb_data, cyc);
                        checks++;
                        failures++;
                    end else begin
                        w = exp_wr.pop_front();
                        check("fb_write{addr,data,cyc}",
                              (longint'(fb_addr) << 40) | (longint'(fb_data) << 32) | cyc,
                              (longint'(w.addr) << 40) | (longint'(w.data) << 32) | w.cyc);
                    end
                end
                if (done != '0) begin
                    check("busy_at_done", busy, 1);
                    if (exp_dn.size() == 0) begin
                        $display("FAIL unexpected_done: done %b at cycle %0d", done, cyc);
                        checks++;
                        failures++;
                    end else begin
                        d = exp_dn.pop_front();
                        check("done{mask,cyc}", (longint'(done) << 32) | cyc,
                              (longint'(1 << d.g) << 32) | d.cyc);
                    end
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
    endtask

    // Single requester; its req drops and its inputs are scrambled right after the grant.
    task automatic solo(input int g, input int id, input int x, input int y, input int stall_k,
                        input int stall_len, input int abort_at, output int nw, output int ne);
        int c0, wr0;
        bit fin;
        sprite_id[g*SPR_BITS +: SPR_BITS] = 3'(id);
        pos_x[g*8 +: 8] = 8'(x);
        pos_y[g*8 +: 8] = 8'(y);
        req = '0;
        req[g] = 1'b1;
        c0 = cyc;
        wr0 = n_wr;
        check("busy_before_grant", busy, 0);
        ne = push_blit(g, id, x, y, c0, (abort_at > 0) ? abort_at - 3 : 256, stall_k, stall_len);
        fin = 1'b0;
        for (int t = 1; t <= 400 && !fin; t++) begin
            @(posedge Clk);
            #1;
            if (t == 1) begin
                check("busy_first_run_cycle", busy, 1);
                req[g] = 1'b0;
            end
            sprite_id[g*SPR_BITS +: SPR_BITS] = 3'($urandom);
            pos_x[g*8 +: 8] = 8'($urandom);
            pos_y[g*8 +: 8] = 8'($urandom);
            if (stall_len > 0 && t == stall_k + 3) fb_wait = 1'b1;
            if (stall_len > 0 && t == stall_k + 3 + stall_len) fb_wait = 1'b0;
            if (abort_at > 0 && t == abort_at) begin
                Reset = 1'b1;
            end else if (abort_at > 0 && t == abort_at + 1) begin
                check_idle_outputs("after_abort");
                Reset = 1'b0;
                fin = 1'b1;
            end else if (abort_at == 0 && t >= 2 && !busy) begin
                fin = 1'b1;
            end
        end
        if (!fin) fail("solo_timeout");
        m_rr = (abort_at > 0) ? 0 : (g + 1) % N_REQ;
        nw = n_wr - wr0;
    endtask

    // Several requesters raised together, each dropping its req once its done arrives.
    task automatic group(input int mask);
        int ids[N_REQ], xs[N_REQ], ys[N_REQ];
        int left, n, g, c0, unused;
        bit fin;
        for (int i = 0; i < N_REQ; i++) begin
            ids[i] = $urandom_range(0, 7);
            xs[i]  = $urandom_range(0, 255);
            ys[i]  = $urandom_range(0, 255);
            sprite_id[i*SPR_BITS +: SPR_BITS] = 3'(ids[i]);
            pos_x[i*8 +: 8] = 8'(xs[i]);
            pos_y[i*8 +: 8] = 8'(ys[i]);
        end
        c0 = cyc;
        left = mask;
        n = 0;
        while (left != 0) begin
            g = pick(m_rr, left);
            unused = push_blit(g, ids[g], xs[g], ys[g], c0 + 260 * n, 256, 0, 0);
            m_rr = (g + 1) % N_REQ;
            left = left & ~(1 << g);
            n++;
        end
        req = 4'(mask);
        fin = 1'b0;
        for (int t = 1; t <= 260 * N_REQ + 50 && !fin; t++) begin
            @(posedge Clk);
            #1;
            req = req & ~done;
            if (req == '0 && !busy) fin = 1'b1;
        end
        if (!fin) fail("group_timeout");
    endtask

    initial begin
        int nw, ne;
        Reset = 1'b1;
        req = '0;
        sprite_id = '0;
        pos_x = '0;
        pos_y = '0;
        fb_wait = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check_idle_outputs("reset");

        rom_mode = 0;
        solo(0, 0, 0, 0, 0, 0, 0, nw, ne);
        check("single_write_count", nw, 256);

        rom_mode = 1;
        fb_wait = 1'b1;
        solo(0, 0, 0, 0, 0, 0, 0, nw, ne);
        fb_wait = 1'b0;
        check("transparent_write_count", nw, 0);

        rom_mode = 0;
        solo(0, $urandom_range(0, 7), 200, 200, 0, 0, 0, nw, ne);
        check("clip_write_count", nw, 64);

        rom_mode = 2;
        rom_seed = $urandom_range(0, 1000);
        group(4'b1111);
        group(4'b0101);

        // Pick a seed whose pixel 5 of sprite 0 is opaque so the stall lands on a real write.
        rom_seed = $urandom_range(0, 1000);
        while (rom_val(2, rom_seed, 5) == 4'd0) rom_seed++;
        solo(0, 0, 0, 0, 5, 10, 0, nw, ne);
        check("stall_write_count", nw, ne);

        for (int i = 0; i < 3; i++) begin
            rom_seed = $urandom_range(0, 1000);
            solo($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 255),
                 $urandom_range(0, 255), 0, 0, 0, nw, ne);
            check("random_write_count", nw, ne);
        end

        solo(0, $urandom_range(0, 7), $urandom_range(0, 100), $urandom_range(0, 100),
             0, 0, 100, nw, ne);
        group(4'b1010);

        repeat (5) @(posedge Clk);
        #1;
        check("leftover_expected_writes", exp_wr.size(), 0);
        check("leftover_expected_dones", exp_dn.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
